// File: rtl/seq_divider_8x4.sv
// seq_divider_8x4: unsigned 8-bit by 4-bit restoring divider, one quotient bit per clock.
// Divide-by-zero skips iteration and reports Q=FF, R=0 with err set.
module seq_divider_8x4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state_q, state_d;
  logic [7:0] d_q, d_d, q_q, q_d;
  logic [3:0] v_q, v_d, r_q, r_d;
  logic [4:0] p_q, p_d, t, p_next;
  logic [2:0] cnt_q, cnt_d;
  logic       err_q, err_d, start, accept, ge, unused_ok;
  assign start     = uio_in[4];
  assign accept    = start && (state_q == IDLE || state_q == DONE);
  assign t         = {p_q[3:0], d_q[cnt_q]};
  assign ge        = t >= {1'b0, v_q};
  assign p_next    = ge ? t - {1'b0, v_q} : t;
  assign unused_ok = &{1'b0, ena, uio_in[7:6]};
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    v_d     = v_q;
    q_d     = q_q;
    r_d     = r_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (accept) begin
      d_d     = ui_in;
      v_d     = uio_in[3:0];
      p_d     = '0;
      cnt_d   = 3'd7;
      r_d     = '0;
      err_d   = uio_in[3:0] == 4'd0;
      q_d     = uio_in[3:0] == 4'd0 ? 8'hFF : 8'h00;
      state_d = uio_in[3:0] == 4'd0 ? DONE : RUN;
    end else if (state_q == RUN) begin
      p_d        = p_next;
      q_d[cnt_q] = ge;
      cnt_d      = cnt_q - 3'd1;
      r_d        = cnt_q == 3'd0 ? p_next[3:0] : r_q;
      state_d    = cnt_q == 3'd0 ? DONE : RUN;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      d_q     <= '0;
      v_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      p_q     <= '0;
      cnt_q   <= 3'd7;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      v_q     <= v_d;
      q_q     <= q_d;
      r_q     <= r_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
  assign uo_out  = uio_in[5] ? {err_q, 3'b000, r_q} : q_q;
  assign uio_out = {state_q == DONE, state_q == RUN, 6'b0};
  assign uio_oe  = 8'hC0;
endmodule

// File: tb/tb_seq_divider_8x4.sv
// tb_seq_divider_8x4: table vectors, corner sequences, random ops and a back-to-back sweep
// checked against plain integer division.
module tb_seq_divider_8x4;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;
  int errs = 0;
  int checks = 0;

  seq_divider_8x4 dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [3:0] v;
    logic [7:0] q;
    logic [7:0] st;
    int         lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Starts one operation, scrambles inputs after acceptance, waits for done.
  task automatic run_op(input logic [7:0] d, input logic [3:0] v, output logic [7:0] q,
                        output logic [7:0] st, output int lat, output int busy_n, output int both);
    ui_in  = d;
    uio_in = {2'b10, 1'b0, 1'b1, v};
    tick;
    uio_in = {2'b01, 1'b0, 1'b0, ~v};
    ui_in  = ~d;
    lat    = 0;
    busy_n = 0;
    both   = 0;
    while (!uio_out[7] && lat < 20) begin
      if (uio_out[6]) busy_n++;
      tick;
      lat++;
      if (uio_out[6] && uio_out[7]) both++;
    end
    q = uo_out;
    uio_in[5] = 1'b1;
    #1 st = uo_out;
    uio_in[5] = 1'b0;
    #1;
  endtask

  vec_t tbl[5];
  logic [7:0] gq, gst, eq, est;
  int lat, busy_n, both, n, cd, cv, dn;

  initial begin
    tbl[0] = '{d: 8'd143, v: 4'd11, q: 8'h0D, st: 8'h00, lat: 8};
    tbl[1] = '{d: 8'd200, v: 4'd15, q: 8'h0D, st: 8'h05, lat: 8};
    tbl[2] = '{d: 8'd255, v: 4'd1,  q: 8'hFF, st: 8'h00, lat: 8};
    tbl[3] = '{d: 8'd7,   v: 4'd9,  q: 8'h00, st: 8'h07, lat: 8};
    tbl[4] = '{d: 8'd77,  v: 4'd0,  q: 8'hFF, st: 8'h80, lat: 0};

    // reset state, both sel values
    ui_in  = 8'hA5;
    uio_in = 8'h07;
    #12;
    chk("rst_uo_sel0", uo_out, 8'h00);
    uio_in[5] = 1'b1;
    #1 chk("rst_uo_sel1", uo_out, 8'h00);
    chk("rst_uio_out", uio_out, 8'h00);
    chk("rst_uio_oe", uio_oe, 8'hC0);
    uio_in = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      run_op(tbl[i].d, tbl[i].v, gq, gst, lat, busy_n, both);
      chk($sformatf("vec%0d_q", i), gq, tbl[i].q);
      chk($sformatf("vec%0d_st", i), gst, tbl[i].st);
      chk($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("vec%0d_busy", i), busy_n, tbl[i].lat);
      chk($sformatf("vec%0d_overlap", i), both, 0);
    end

    // DONE holds its result while idle
    repeat (5) tick;
    chk("hold_done", uio_out[7], 1'b1);
    chk("hold_q", uo_out, 8'hFF);

    // start during RUN is ignored
    ui_in  = 8'd100;
    uio_in = {4'b0001, 4'd7};
    tick;
    uio_in[4] = 1'b0;
    repeat (2) tick;
    ui_in  = 8'd9;
    uio_in = {4'b0001, 4'd3};
    n = 2;
    while (!uio_out[7] && n < 20) begin
      tick;
      n++;
    end
    uio_in[4] = 1'b0;
    chk("ign_lat", n, 8);
    chk("ign_q", uo_out, 8'd14);
    uio_in[5] = 1'b1;
    #1 chk("ign_st", uo_out, 8'h02);
    uio_in[5] = 1'b0;

    // asynchronous reset mid-run aborts
    ui_in  = 8'd250;
    uio_in = {4'b0001, 4'd13};
    tick;
    uio_in[4] = 1'b0;
    repeat (4) tick;
    #2 rst_n = 1'b0;
    #1 chk("arst_busy", uio_out, 8'h00);
    chk("arst_uo_sel0", uo_out, 8'h00);
    uio_in[5] = 1'b1;
    #1 chk("arst_uo_sel1", uo_out, 8'h00);
    uio_in[5] = 1'b0;
    tick;
    rst_n = 1'b1;
    dn = 0;
    repeat (12) begin
      tick;
      if (uio_out[7] || uio_out[6]) dn++;
    end
    chk("arst_no_done", dn, 0);

    // random operations against integer division
    repeat (40) begin
      cd = int'($urandom_range(0, 255));
      cv = int'($urandom_range(0, 15));
      eq  = cv != 0 ? 8'(cd / cv) : 8'hFF;
      est = cv != 0 ? 8'(cd % cv) : 8'h80;
      run_op(8'(cd), 4'(cv), gq, gst, lat, busy_n, both);
      chk($sformatf("rnd_q %0d/%0d", cd, cv), gq, eq);
      chk($sformatf("rnd_st %0d/%0d", cd, cv), gst, est);
      chk($sformatf("rnd_lat %0d/%0d", cd, cv), lat, cv != 0 ? 8 : 0);
    end

    // back-to-back sweep of every D with every nonzero V, start held high
    ui_in  = 8'd0;
    uio_in = {4'b0001, 4'd1};
    tick;
    for (int i = 0; i < 3840; i++) begin
      cd = i / 15;
      cv = i % 15 + 1;
      n  = 0;
      while (!uio_out[7] && n < 20) begin
        tick;
        n++;
      end
      gq = uo_out;
      uio_in[5] = 1'b1;
      #1 gst = uo_out;
      uio_in[5] = 1'b0;
      checks++;
      if (n != 8 || int'(gq) * cv + int'(gst[3:0]) != cd || int'(gst[3:0]) >= cv || gst[7:4] != 4'h0) begin
        errs++;
        $display("FAIL sweep %0d/%0d: got q=%0d st=%0h lat=%0d required q*v+r=d, r<v, lat=8",
                 cd, cv, gq, gst, n);
      end
      ui_in  = 8'((i + 1) / 15);
      uio_in = {3'b000, i < 3839, 4'((i + 1) % 15 + 1)};
      tick;
      if (i == 0) chk("b2b_done_low", uio_out[7], 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
